snake_game_ctrl: RTL and testbench
==================================

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 6, initial number of animate pulses per snake step (2..15).
REQ-002 SHALL have parameter MIN_FRAMES, default 2, fastest allowed frames per step.
REQ-003 SHALL have parameter SPEEDUP_EVERY, default 4, food count between speed increases.
REQ-004 SHALL have port clk  input  1  25 MHz pixel clock, the only clock; all logic on its rising edge.
REQ-005 SHALL have port arst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port animate  input  1  one-cycle pulse at end of each VGA frame.
REQ-007 SHALL have port move  input  3  key code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 start; 6-7 ignored.
REQ-008 SHALL have port collide  input  1  one-cycle pulse, head hit wall or body.
REQ-009 SHALL have port food_hit  input  1  one-cycle pulse, head reached food.
REQ-010 SHALL have port step  output  1  one-cycle pulse: advance snake one cell.
REQ-011 SHALL have port dir  output  2  committed direction: 0 up, 1 down, 2 left, 3 right.
REQ-012 SHALL have port grow  output  1  one-cycle pulse: lengthen snake by one on next step.
REQ-013 SHALL have port clear  output  1  one-cycle pulse: reinitialise snake body and food.
REQ-014 SHALL have port score  output  8  foods eaten this game, binary.
REQ-015 SHALL have port state  output  2  0 IDLE, 1 INIT, 2 PLAY, 3 DEAD.

Function
REQ-016 SHALL implement FSM IDLE, INIT, PLAY, DEAD; registered outputs, no combinational input-to-output path.
REQ-017 IDLE: move==5 SHALL go to INIT next cycle; other inputs ignored.
REQ-018 INIT SHALL last exactly one cycle, assert clear for that cycle, set score=0, dir=3, pending dir=3, frame counter=0, period=FRAMES_PER_STEP, food count=0, then enter PLAY.
REQ-019 PLAY: frame counter SHALL increment on each animate; when animate arrives with counter==period-1, counter SHALL go to 0 and step SHALL pulse the following cycle.
REQ-020 move 1-4 in PLAY SHALL load pending dir unless it is the exact reverse of committed dir, in which case it SHALL be discarded; last accepted key before a step wins.
REQ-021 Committed dir SHALL take pending dir in the same cycle step is asserted; dir is stable between steps.
REQ-022 food_hit in PLAY SHALL, next cycle, pulse grow, increment score saturating at 255, increment food count.
REQ-023 When food count reaches SPEEDUP_EVERY it SHALL reset to 0 and period SHALL decrement by 1, not below MIN_FRAMES; new period applies from the next counter wrap.
REQ-024 collide in PLAY SHALL enter DEAD next cycle; no further step, grow or score change.
REQ-025 collide and food_hit in the same cycle: collide SHALL win, score unchanged, no grow.
REQ-026 animate coincident with any other event SHALL still be counted.
REQ-027 DEAD: score SHALL hold; move==5 SHALL go to INIT; collide/food_hit ignored.
REQ-028 collide, food_hit, move outside their stated states SHALL have no effect.

Reset
REQ-029 arst low SHALL immediately force state=IDLE, step=0, grow=0, clear=0, score=0, dir=3, counters=0, period=FRAMES_PER_STEP, regardless of state or pending pulses.
REQ-030 Release of arst SHALL be synchronised; first active edge after release leaves all outputs at reset values.
REQ-031 Reset asserted mid-game SHALL discard pending dir and any in-flight step/grow pulse.

Verification
REQ-032 Reset then move=5 one cycle -> state 1 for one cycle with clear=1, then state 2, score=0, dir=3.
REQ-033 PLAY, 12 animate pulses, defaults -> exactly 2 step pulses, each one cycle after 6th and 12th animate.
REQ-034 dir=3, move=3 (left) then move=1 (up) before step -> left discarded, dir=0 at next step.
REQ-035 8 food_hit pulses, defaults -> score=8, 8 grow pulses, period 4; collide+food_hit same cycle -> state 3, score unchanged.
REQ-036 Score at 255 plus food_hit -> score stays 255; arst low mid-PLAY -> state 0, score 0 same cycle, no step after release.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: paces snake steps off VGA frame pulses, filters direction keys,
// tracks score and speeds up play as food is eaten.
module snake_game_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 6,
    parameter int unsigned MIN_FRAMES      = 2,
    parameter int unsigned SPEEDUP_EVERY   = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       animate,
    input  logic [2:0] move,
    input  logic       collide,
    input  logic       food_hit,
    output logic       step,
    output logic [1:0] dir,
    output logic       grow,
    output logic       clear,
    output logic [7:0] score,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StInit = 2'd1,
        StPlay = 2'd2,
        StDead = 2'd3
    } state_e;

    localparam logic [3:0] InitPeriod = 4'(FRAMES_PER_STEP);
    localparam logic [3:0] MinPeriod  = 4'(MIN_FRAMES);
    localparam logic [7:0] FoodLast   = 8'(SPEEDUP_EVERY - 1);

    // Reset asserts asynchronously but releases two edges after arst rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    state_e     state_q, state_d;
    logic [1:0] dir_q, dir_d, pend_q, pend_d;
    logic [3:0] frame_q, frame_d;
    logic [3:0] period_q, period_d;
    logic [3:0] cur_period_q, cur_period_d;
    logic [7:0] food_q, food_d;
    logic [7:0] score_q, score_d;
    logic       step_q, step_d, grow_q, grow_d, clear_q, clear_d;
    logic [1:0] key;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        frame_d      = frame_q;
        period_d     = period_q;
        cur_period_d = cur_period_q;
        food_d       = food_q;
        score_d      = score_q;
        step_d       = 1'b0;
        grow_d       = 1'b0;
        clear_d      = 1'b0;
        key          = move[1:0] - 2'd1;

        unique case (state_q)
            StIdle, StDead: begin
                if (move == 3'd5) begin
                    state_d      = StInit;
                    clear_d      = 1'b1;
                    score_d      = 8'd0;
                    dir_d        = 2'd3;
                    pend_d       = 2'd3;
                    frame_d      = 4'd0;
                    period_d     = InitPeriod;
                    cur_period_d = InitPeriod;
                    food_d       = 8'd0;
                end
            end
            StInit: state_d = StPlay;
            StPlay: begin
                // Reversal is judged against the committed direction, not the pending one.
                if (move >= 3'd1 && move <= 3'd4 && key != (dir_q ^ 2'b01)) pend_d = key;
                if (food_hit && !collide) begin
                    grow_d = 1'b1;
                    if (score_q != 8'hff) score_d = score_q + 8'd1;
                    if (food_q == FoodLast) begin
                        food_d = 8'd0;
                        if (period_q > MinPeriod) period_d = period_q - 4'd1;
                    end else begin
                        food_d = food_q + 8'd1;
                    end
                end
                if (animate) begin
                    if (frame_q == cur_period_q - 4'd1) begin
                        frame_d      = 4'd0;
                        cur_period_d = period_d;
                        if (!collide) begin
                            step_d = 1'b1;
                            dir_d  = pend_d;
                        end
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
                if (collide) state_d = StDead;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dir_q        <= 2'd3;
            pend_q       <= 2'd3;
            frame_q      <= 4'd0;
            period_q     <= InitPeriod;
            cur_period_q <= InitPeriod;
            food_q       <= 8'd0;
            score_q      <= 8'd0;
            step_q       <= 1'b0;
            grow_q       <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            frame_q      <= frame_d;
            period_q     <= period_d;
            cur_period_q <= cur_period_d;
            food_q       <= food_d;
            score_q      <= score_d;
            step_q       <= step_d;
            grow_q       <= grow_d;
            clear_q      <= clear_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign grow  = grow_q;
    assign clear = clear_q;
    assign score = score_q;
    assign state = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: a game-rule model predicts every output per cycle,
// a monitor pops and compares the predictions after each rising edge.
module tb_snake_game_ctrl;

    localparam int FPS  = 6;
    localparam int MINF = 2;
    localparam int SPD  = 4;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       animate = 1'b0;
    logic [2:0] move = 3'd0;
    logic       collide = 1'b0;
    logic       food_hit = 1'b0;
    logic       step, grow, clear;
    logic [1:0] dir, state;
    logic [7:0] score;

    snake_game_ctrl #(
        .FRAMES_PER_STEP(FPS),
        .MIN_FRAMES     (MINF),
        .SPEEDUP_EVERY  (SPD)
    ) dut (
        .clk     (clk),
        .arst    (arst),
        .animate (animate),
        .move    (move),
        .collide (collide),
        .food_hit(food_hit),
        .step    (step),
        .dir     (dir),
        .grow    (grow),
        .clear   (clear),
        .score   (score),
        .state   (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int sc;
        int dr;
        int stp;
        int grw;
        int clr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Game-level model state
    int m_state, m_score, m_dir, m_pend, m_frames, m_period, m_active, m_food, m_hold;
    int m_step, m_grow, m_clear;
    int key_dir[8] = '{-1, 0, 1, 2, 3, -1, -1, -1};
    int opposite[4] = '{1, 0, 3, 2};

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_score  = 0;
        m_dir    = 3;
        m_pend   = 3;
        m_frames = 0;
        m_period = FPS;
        m_active = FPS;
        m_food   = 0;
        m_step   = 0;
        m_grow   = 0;
        m_clear  = 0;
    endtask

    task automatic model_tick(input int an, input int mv, input int col, input int fh);
        m_step  = 0;
        m_grow  = 0;
        m_clear = 0;
        if (arst == 1'b0) begin
            model_reset();
            m_hold = 2;
            return;
        end
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        case (m_state)
            0, 3: begin
                if (mv == 5) begin
                    model_reset();
                    m_state = 1;
                    m_clear = 1;
                end
            end
            1: m_state = 2;
            default: begin
                if (key_dir[mv] >= 0 && key_dir[mv] != opposite[m_dir]) m_pend = key_dir[mv];
                if (col != 0) begin
                    m_state = 3;
                    return;
                end
                if (fh != 0) begin
                    m_grow  = 1;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_food++;
                    if (m_food == SPD) begin
                        m_food   = 0;
                        m_period = (m_period - 1 < MINF) ? MINF : m_period - 1;
                    end
                end
                if (an != 0) begin
                    m_frames++;
                    if (m_frames == m_active) begin
                        m_frames = 0;
                        m_active = m_period;
                        m_step   = 1;
                        m_dir    = m_pend;
                    end
                end
            end
        endcase
    endtask

    task automatic tick(input int an, input int mv, input int col, input int fh);
        exp_t e;
        animate  = 1'(an);
        move     = 3'(mv);
        collide  = 1'(col);
        food_hit = 1'(fh);
        model_tick(an, mv, col, fh);
        e = '{m_state, m_score, m_dir, m_step, m_grow, m_clear};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_dir", int'(dir), 3);
        chk("rst_step", int'(step), 0);
        chk("rst_grow", int'(grow), 0);
        chk("rst_clear", int'(clear), 0);
        tick(0, 0, 0, 0);
        tick(1, 5, 0, 1);
        arst = 1'b1;
        tick(1, 5, 1, 1);
        tick(1, 5, 0, 1);
        tick(0, 0, 0, 0);
    endtask

    task automatic rand_tick(input int col_mod);
        int an, mv, col, fh;
        an  = ($urandom_range(0, 2) == 0) ? 1 : 0;
        mv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
        fh  = ($urandom_range(0, 9) == 0) ? 1 : 0;
        col = ($urandom_range(0, col_mod) == 0) ? 1 : 0;
        if ((m_state == 0 || m_state == 3) && $urandom_range(0, 5) == 0) mv = 5;
        tick(an, mv, col, fh);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(state), e.st);
            chk("score", int'(score), e.sc);
            chk("dir", int'(dir), e.dr);
            chk("step", int'(step), e.stp);
            chk("grow", int'(grow), e.grw);
            chk("clear", int'(clear), e.clr);
        end
    end

    initial begin
        int mv;
        model_reset();
        m_hold = 0;
        @(negedge clk);
        do_reset();

        // IDLE ignores everything but start
        for (int i = 0; i < 8; i++) begin
            mv = int'($urandom_range(0, 7));
            if (mv == 5) mv = 6;
            tick(int'($urandom_range(0, 1)), mv, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
        end
        tick(0, 5, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Twelve frames at the initial rate
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end

        // Reverse key discarded, later legal key wins
        tick(0, 3, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);

        // Eight foods speed the game up twice
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 1);
            tick(0, 0, 0, 0);
        end
        for (int i = 0; i < 14; i++) tick(1, 0, 0, 0);

        // Collision beats food; DEAD ignores events
        tick(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) tick(1, int'($urandom_range(0, 4)), 1, 1);

        // Score saturation
        tick(0, 5, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            tick(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 0, 1);

        // Reset mid-play, right after a wrapping frame
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        do_reset();
        tick(0, 5, 0, 0);
        tick(0, 0, 0, 0);

        // Random play with occasional mid-game resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else rand_tick(149);
        end

        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
